sr04_ranging_ctrl: RTL and testbench

//  Sequencer for one HC-SR04 ultrasonic ranging cycle in the fan project.
//  - Issues the trigger pulse and waits for the echo.
//  - Gates an internal usec-to-cm counter while echo is high.
//  - Latches the finished distance and raises a valid strobe.
//  - Flags a timeout when no echo arrives, or when the echo never ends.
//  - Sits between the usec tick generator and the fan speed/display logic.

---
 rtl/sr04_pkg.sv | 26 ++
 rtl/sr04_cm_counter.sv | 41 ++++
 rtl/sr04_ranging_ctrl.sv | 123 ++++++++++++
 tb/tb_sr04_ranging_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared types and default timing for the HC-SR04 ranging sequencer.
// Shared by the top-level controller and the centimetre counter.
package sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int unsigned DEF_TRIG_US         = 10;
  localparam int unsigned DEF_ECHO_TIMEOUT_US = 30000;
  localparam int unsigned DEF_HOLDOFF_US      = 60000;
  localparam int unsigned DEF_US_PER_CM       = 58;
  localparam int unsigned DEF_CM_W            = 12;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sr04_cm_counter.sv
// Divide-by-US_PER_CM tick counter producing whole centimetres of echo time.
// Held at zero while disabled, so each enable window starts from a clean count.
module sr04_cm_counter
  import sr04_pkg::*;
#(
  parameter int unsigned US_PER_CM = DEF_US_PER_CM,
  parameter int unsigned CM_W      = DEF_CM_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_usec,
  input  logic            en,
  output logic [CM_W-1:0] cm
);

  localparam int unsigned     SUB_W    = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(US_PER_CM - 1);
  localparam logic [CM_W-1:0]  CM_MAX   = '1;

  logic [SUB_W-1:0] sub;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub <= '0;
      cm  <= '0;
    end else if (!en) begin
      sub <= '0;
      cm  <= '0;
    end else if (clk_usec) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        if (cm != CM_MAX) cm <= cm + 1'b1;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr04_ranging_ctrl.sv
// One HC-SR04 ranging cycle: trigger, wait for echo, time it in cm, hold off.
// Echo is synchronized and edge-detected; every output is registered.
module sr04_ranging_ctrl
  import sr04_pkg::*;
#(
  parameter int unsigned TRIG_US         = DEF_TRIG_US,
  parameter int unsigned ECHO_TIMEOUT_US = DEF_ECHO_TIMEOUT_US,
  parameter int unsigned HOLDOFF_US      = DEF_HOLDOFF_US,
  parameter int unsigned US_PER_CM       = DEF_US_PER_CM,
  parameter int unsigned CM_W            = DEF_CM_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_usec,
  input  logic            start,
  input  logic            auto_en,
  input  logic            echo,
  output logic            trig,
  output logic [CM_W-1:0] distance_cm,
  output logic            valid,
  output logic            timeout,
  output logic            busy
);

  localparam int unsigned US_W = $clog2(max3(TRIG_US, ECHO_TIMEOUT_US, HOLDOFF_US) + 1);

  state_t          state, next_state;
  logic [US_W-1:0] us_cnt;
  logic            echo_meta, echo_sync, echo_prev;
  logic            echo_rise, echo_fall;
  logic            trig_hit, echo_to_hit, holdoff_hit;
  logic            cm_en;
  logic [CM_W-1:0] cm;
  logic            trig_d, busy_d, valid_d, timeout_set, timeout_clr;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  assign echo_rise   = echo_sync & ~echo_prev;
  assign echo_fall   = ~echo_sync & echo_prev;
  assign trig_hit    = (us_cnt == US_W'(TRIG_US));
  assign echo_to_hit = (us_cnt == US_W'(ECHO_TIMEOUT_US));
  assign holdoff_hit = (us_cnt == US_W'(HOLDOFF_US));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state takes its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:      if (start | auto_en) next_state = ST_TRIG;
      ST_TRIG:      if (trig_hit) next_state = ST_WAIT_RISE;
      ST_WAIT_RISE: if (echo_rise || echo_to_hit) next_state = echo_rise ? ST_MEASURE : ST_HOLDOFF;
      ST_MEASURE:   if (echo_fall || echo_to_hit) next_state = ST_HOLDOFF;
      ST_HOLDOFF:   if (holdoff_hit) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Edges win over a coincident timeout, so timeout is only set without one.
  always_comb begin
    trig_d      = (next_state == ST_TRIG);
    busy_d      = (next_state != ST_IDLE);
    valid_d     = (state == ST_MEASURE) && echo_fall;
    timeout_set = ((state == ST_WAIT_RISE) && !echo_rise && echo_to_hit) ||
                  ((state == ST_MEASURE)   && !echo_fall && echo_to_hit);
    timeout_clr = (state == ST_IDLE) && (next_state == ST_TRIG);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig        <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      distance_cm <= '0;
    end else begin
      trig  <= trig_d;
      busy  <= busy_d;
      valid <= valid_d;
      if (valid_d)          distance_cm <= cm;
      if (timeout_clr)      timeout     <= 1'b0;
      else if (timeout_set) timeout     <= 1'b1;
    end
  end

  // Cleared on every state change; the per-state compares see fresh counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       us_cnt <= '0;
    else if (next_state != state || state == ST_IDLE)   us_cnt <= '0;
    else if (clk_usec)                                  us_cnt <= us_cnt + 1'b1;
  end

  // Enabled from the entry edge up to the fall edge so the latched count
  // covers the whole echo window, not one tick less.
  assign cm_en = (next_state == ST_MEASURE);

  sr04_cm_counter #(
    .US_PER_CM (US_PER_CM),
    .CM_W      (CM_W)
  ) u_cm_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_usec (clk_usec),
    .en       (cm_en),
    .cm       (cm)
  );

endmodule

// File: tb/tb_sr04_ranging_ctrl.sv
// Randomized self-checking bench for sr04_ranging_ctrl against a simple
// echo-duration model: distance = min(floor(us / US_PER_CM), 2^CM_W - 1).
module tb_sr04_ranging_ctrl;

  localparam int unsigned TRIG_US         = 10;
  localparam int unsigned ECHO_TIMEOUT_US = 3000;
  localparam int unsigned HOLDOFF_US      = 500;
  localparam int unsigned US_PER_CM       = 58;
  localparam int unsigned CM_W            = 12;
  localparam int          TRIG_BUDGET     = 2 * (HOLDOFF_US + TRIG_US) + 400;
  localparam int          BUSY_BUDGET     = 2 * (2 * ECHO_TIMEOUT_US + HOLDOFF_US + TRIG_US) + 400;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clk_usec = 1'b0;
  logic            start = 1'b0;
  logic            auto_en = 1'b0;
  logic            echo = 1'b0;
  logic            trig, valid, timeout, busy;
  logic [CM_W-1:0] distance_cm;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_dist = 0;

  sr04_ranging_ctrl #(
    .TRIG_US         (TRIG_US),
    .ECHO_TIMEOUT_US (ECHO_TIMEOUT_US),
    .HOLDOFF_US      (HOLDOFF_US),
    .US_PER_CM       (US_PER_CM),
    .CM_W            (CM_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_usec    (clk_usec),
    .start       (start),
    .auto_en     (auto_en),
    .echo        (echo),
    .trig        (trig),
    .distance_cm (distance_cm),
    .valid       (valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One-clk microsecond tick every second clock keeps the run short.
  initial begin
    forever begin
      @(posedge clk);
      #1 clk_usec = ~clk_usec;
    end
  end

  // Event monitor: timestamps in microsecond ticks seen by the DUT.
  int              us_time = 0;
  int              t_trig_rise = 0, t_trig_fall = 0, t_valid = 0, t_timeout = 0, t_busy_fall = 0;
  int              trig_rises = 0, valid_cnt = 0, valid_long = 0;
  int              rise_q[$];
  logic [CM_W-1:0] valid_dist = '0;
  logic            trig_q = 1'b0, valid_q = 1'b0, timeout_q = 1'b0, busy_q = 1'b0;

  always @(negedge clk) begin
    if (trig === 1'b1 && trig_q === 1'b0) begin
      trig_rises++;
      t_trig_rise = us_time;
      rise_q.push_back(us_time);
    end
    if (trig === 1'b0 && trig_q === 1'b1) t_trig_fall = us_time;
    if (valid === 1'b1) begin
      valid_cnt++;
      valid_dist = distance_cm;
      t_valid    = us_time;
      if (valid_q === 1'b1) valid_long++;
    end
    if (timeout === 1'b1 && timeout_q === 1'b0) t_timeout = us_time;
    if (busy === 1'b0 && busy_q === 1'b1) t_busy_fall = us_time;
    trig_q    = trig;
    valid_q   = valid;
    timeout_q = timeout;
    busy_q    = busy;
    if (clk_usec === 1'b1) us_time++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_cm(input int echo_us);
    int c;
    c = echo_us / int'(US_PER_CM);
    return (c > (1 << CM_W) - 1) ? (1 << CM_W) - 1 : c;
  endfunction

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_echo(input int delay_us, input int dur_us);
    repeat (2 * delay_us) @(posedge clk);
    #1 echo = 1'b1;
    repeat (2 * dur_us) @(posedge clk);
    #1 echo = 1'b0;
  endtask

  task automatic wait_trig_done(input string tag);
    bit seen = 1'b0;
    int i = 0;
    while (i < TRIG_BUDGET && !(seen && trig === 1'b0)) begin
      @(negedge clk);
      if (trig === 1'b1) seen = 1'b1;
      i++;
    end
    #1;
    check({tag, " trig pulse seen"}, {31'd0, seen && trig === 1'b0}, 1);
  endtask

  task automatic wait_busy_low(input string tag);
    int i = 0;
    while (i < BUSY_BUDGET && busy !== 1'b0) begin
      @(negedge clk);
      i++;
    end
    #1;
    check({tag, " busy low"}, {31'd0, busy}, 0);
  endtask

  task automatic wait_valid(input string tag, input int v0);
    int i = 0;
    while (i < BUSY_BUDGET && valid_cnt == v0) begin
      @(negedge clk);
      i++;
    end
    #1;
    check({tag, " valid count"}, valid_cnt - v0, 1);
  endtask

  task automatic measure_cycle(input string tag, input int delay_us, input int dur_us);
    int v0, exp_cm;
    v0     = valid_cnt;
    exp_cm = model_cm(dur_us);
    do_start();
    wait_trig_done(tag);
    check({tag, " trig width us"}, t_trig_fall - t_trig_rise, TRIG_US);
    check({tag, " timeout cleared"}, {31'd0, timeout}, 0);
    drive_echo(delay_us, dur_us);
    wait_busy_low(tag);
    check({tag, " valid count"}, valid_cnt - v0, 1);
    check({tag, " latched cm"}, {20'd0, valid_dist}, exp_cm);
    check({tag, " held cm"}, {20'd0, distance_cm}, exp_cm);
    check({tag, " no timeout"}, {31'd0, timeout}, 0);
    check({tag, " holdoff us"}, t_busy_fall - t_valid, HOLDOFF_US);
    exp_dist = exp_cm;
  endtask

  task automatic timeout_checks(input string tag, input int v0);
    check({tag, " timeout set"}, {31'd0, timeout}, 1);
    check({tag, " no valid"}, valid_cnt - v0, 0);
    check({tag, " cm kept"}, {20'd0, distance_cm}, exp_dist);
    check({tag, " holdoff us"}, t_busy_fall - t_timeout, HOLDOFF_US);
  endtask

  initial begin
    int v0, r0, d;
    int bounds[4] = '{1, 58, 115, 116};

    repeat (3) @(negedge clk);
    check("reset trig", {31'd0, trig}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset valid", {31'd0, valid}, 0);
    check("reset timeout", {31'd0, timeout}, 0);
    check("reset cm", {20'd0, distance_cm}, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    measure_cycle("echo580", 37, 580);

    // No echo at all: timeout exactly ECHO_TIMEOUT_US after trig falls.
    v0 = valid_cnt;
    do_start();
    wait_trig_done("noecho");
    wait_busy_low("noecho");
    check("noecho timeout us", t_timeout - t_trig_fall, ECHO_TIMEOUT_US);
    timeout_checks("noecho", v0);

    // Short echo below one cm, then a start during holdoff must be dropped.
    v0 = valid_cnt;
    do_start();
    wait_trig_done("echo57");
    check("echo57 timeout cleared", {31'd0, timeout}, 0);
    drive_echo(3, 57);
    wait_valid("echo57", v0);
    check("echo57 cm", {20'd0, valid_dist}, model_cm(57));
    check("echo57 busy in holdoff", {31'd0, busy}, 1);
    exp_dist = model_cm(57);
    r0 = trig_rises;
    do_start();
    wait_busy_low("busystart");
    repeat (40) @(negedge clk);
    #1;
    check("busystart no new trig", trig_rises - r0, 0);
    check("busystart idle", {31'd0, busy}, 0);

    foreach (bounds[i]) measure_cycle($sformatf("bound%0d", bounds[i]), 1 + i, bounds[i]);
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(1500, 1);
      measure_cycle($sformatf("rand%0d", d), $urandom_range(100, 1), d);
    end

    // Echo already high when WAIT_RISE is entered is not a rise.
    v0 = valid_cnt;
    do_start();
    @(posedge clk);
    #1 echo = 1'b1;
    wait_trig_done("echohigh");
    wait_busy_low("echohigh");
    check("echohigh timeout us", t_timeout - t_trig_fall, ECHO_TIMEOUT_US);
    timeout_checks("echohigh", v0);
    @(posedge clk);
    #1 echo = 1'b0;
    repeat (10) @(posedge clk);

    // Echo that never ends within the window.
    v0 = valid_cnt;
    do_start();
    wait_trig_done("longecho");
    drive_echo(20, ECHO_TIMEOUT_US + 100);
    wait_busy_low("longecho");
    timeout_checks("longecho", v0);

    // Free-running mode: three cycles, then auto_en drops mid-cycle.
    r0 = trig_rises;
    @(posedge clk);
    #1 auto_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      v0 = valid_cnt;
      wait_trig_done($sformatf("auto%0d", c));
      drive_echo($urandom_range(60, 1), 1160);
      wait_valid($sformatf("auto%0d", c), v0);
      check($sformatf("auto%0d cm", c), {20'd0, valid_dist}, model_cm(1160));
      check($sformatf("auto%0d no timeout", c), {31'd0, timeout}, 0);
    end
    @(posedge clk);
    #1 auto_en = 1'b0;
    wait_busy_low("autostop");
    repeat (100) @(negedge clk);
    #1;
    check("autostop idle", {31'd0, busy}, 0);
    check("auto trig count", trig_rises - r0, 3);
    for (int i = r0 + 1; i < r0 + 3 && i < rise_q.size(); i++)
      check($sformatf("auto gap%0d >= holdoff", i - r0), {31'd0, (rise_q[i] - rise_q[i-1]) >= int'(HOLDOFF_US)}, 1);
    exp_dist = model_cm(1160);

    // Reset in the middle of a measurement.
    do_start();
    wait_trig_done("rstmid");
    repeat (20) @(posedge clk);
    #1 echo = 1'b1;
    repeat (200) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid trig", {31'd0, trig}, 0);
    check("rstmid busy", {31'd0, busy}, 0);
    check("rstmid valid", {31'd0, valid}, 0);
    check("rstmid cm", {20'd0, distance_cm}, 0);
    v0 = valid_cnt;
    echo = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("rstmid idle after release", {31'd0, busy}, 0);
    check("rstmid no valid", valid_cnt - v0, 0);

    check("valid one clk wide", valid_long, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
